// File: rtl/md_pkg.sv
// md_pkg: shared constants for the multiply/divide issue controller.
//   - R-type func codes of the multiply/divide class instructions
//   - MULTsle operation codes (0-7) and the "no operation" code
//   - default busy latencies for mult and div
//   - controller state type and its two legal values
//   - classification helpers on a MULTsle code
package md_pkg;

  // func field of the op=0 instructions handled by the unit
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // MULTsle operation select codes
  localparam logic [3:0] SEL_MULT  = 4'd0;
  localparam logic [3:0] SEL_MULTU = 4'd1;
  localparam logic [3:0] SEL_DIV   = 4'd2;
  localparam logic [3:0] SEL_DIVU  = 4'd3;
  localparam logic [3:0] SEL_MFHI  = 4'd4;
  localparam logic [3:0] SEL_MFLO  = 4'd5;
  localparam logic [3:0] SEL_MTHI  = 4'd6;
  localparam logic [3:0] SEL_MTLO  = 4'd7;
  localparam logic [3:0] SEL_NONE  = 4'd15;

  // default busy latencies in cycles
  localparam int unsigned L_MULT_DEF = 5;
  localparam int unsigned L_DIV_DEF  = 10;

  // controller state
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  // mult/multu/div/divu: operations that start the unit
  function automatic logic is_start(input logic [3:0] sel);
    return sel <= SEL_DIVU;
  endfunction

  // any instruction that touches the unit or hi/lo
  function automatic logic is_md(input logic [3:0] sel);
    return sel <= SEL_MTLO;
  endfunction

endpackage

// File: rtl/md_decode.sv
// md_decode: combinational instruction -> MULTsle decoder.
// Ports:
//   ir  in  32  instruction word
//   sel out  4  operation select (0-7), SEL_NONE for anything else
module md_decode
  import md_pkg::*;
(
  input  logic [31:0] ir,
  output logic [3:0]  sel
);

  // register fields do not affect the decode
  logic unused_fields;
  assign unused_fields = ^ir[25:6];

  always_comb begin
    sel = SEL_NONE;
    if (ir[31:26] == 6'd0) begin
      case (ir[5:0])
        FN_MULT:  sel = SEL_MULT;
        FN_MULTU: sel = SEL_MULTU;
        FN_DIV:   sel = SEL_DIV;
        FN_DIVU:  sel = SEL_DIVU;
        FN_MFHI:  sel = SEL_MFHI;
        FN_MFLO:  sel = SEL_MFLO;
        FN_MTHI:  sel = SEL_MTHI;
        FN_MTLO:  sel = SEL_MTLO;
        default:  sel = SEL_NONE;
      endcase
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue and interlock controller for the E-stage
// multiply/divide unit. Decodes D and E instructions, issues start pulses,
// tracks the unit's latency with a private counter so the front end can be
// stalled from the issue cycle onward, and cross-checks the unit's busy.
// Ports:
//   clk      in   1  clock
//   clr_n    in   1  synchronous active-low reset
//   IR_D     in  32  D-stage instruction
//   IR_E     in  32  E-stage instruction
//   busy     in   1  busy flag from the multiply/divide unit
//   IntReq   in   1  interrupt request (unit frozen this cycle)
//   eret     in   1  exception return (unit frozen this cycle)
//   start    out  1  issue pulse to the unit
//   MULTsle  out  4  E-stage operation select
//   stall_md out  1  freeze PC, IF/ID, ID/EX and bubble E
//   md_done  out  1  registered completion pulse
//   err      out  1  sticky busy-mismatch / illegal-issue flag
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned L_MULT = L_MULT_DEF,
  parameter int unsigned L_DIV  = L_DIV_DEF
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic        busy,
  input  logic        IntReq,
  input  logic        eret,
  output logic        start,
  output logic [3:0]  MULTsle,
  output logic        stall_md,
  output logic        md_done,
  output logic        err
);

  localparam int unsigned L_MAX = (L_MULT > L_DIV) ? L_MULT : L_DIV;
  localparam int unsigned CW    = $clog2(L_MAX + 1);

  // counter reload values: RUN lasts L cycles, counting L-1 down to 0
  localparam logic [CW-1:0] LD_MULT = CW'(L_MULT - 1);
  localparam logic [CW-1:0] LD_DIV  = CW'(L_DIV - 1);

  logic [3:0]    sel_d;
  logic [3:0]    sel_e;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          chk_en;
  logic          frozen;
  logic          in_run;
  logic          busy_err;
  logic          issue_err;

  md_decode u_dec_d (.ir(IR_D), .sel(sel_d));
  md_decode u_dec_e (.ir(IR_E), .sel(sel_e));

  assign MULTsle = sel_e;
  assign frozen  = IntReq | eret;
  assign in_run  = (state == RUN);

  assign start    = clr_n & (state == IDLE) & is_start(sel_e) & ~frozen;
  assign stall_md = clr_n & is_md(sel_d) & (start | in_run);

  // busy comparison is skipped for one cycle after reset, while the unit
  // itself may still be coming out of its own reset
  assign busy_err  = chk_en & (busy != in_run);
  assign issue_err = in_run & is_start(sel_e);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state   <= IDLE;
      cnt     <= '0;
      md_done <= 1'b0;
      err     <= 1'b0;
      chk_en  <= 1'b0;
    end else begin
      chk_en  <= 1'b1;
      md_done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state <= RUN;
          // codes 2/3 are div/divu
          cnt   <= sel_e[1] ? LD_DIV : LD_MULT;
        end
      end else if (!frozen) begin
        // a frozen cycle holds the count, matching the unit's own freeze
        if (cnt == '0) begin
          state   <= IDLE;
          md_done <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
      if (busy_err || issue_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: scoreboard bench for md_issue_ctrl. A stimulus process
// runs a small D/E pipeline, a behavioural model predicts every output each
// cycle and queues the prediction; a monitor pops and compares each cycle.
module tb_md_issue_ctrl;

  localparam int LM = 5;
  localparam int LD = 10;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [31:0] IR_D;
  logic [31:0] IR_E;
  logic        busy;
  logic        IntReq;
  logic        eret;
  logic        start;
  logic [3:0]  MULTsle;
  logic        stall_md;
  logic        md_done;
  logic        err;

  md_issue_ctrl #(.L_MULT(LM), .L_DIV(LD)) dut (
    .clk(clk), .clr_n(clr_n), .IR_D(IR_D), .IR_E(IR_E), .busy(busy),
    .IntReq(IntReq), .eret(eret), .start(start), .MULTsle(MULTsle),
    .stall_md(stall_md), .md_done(md_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       start;
    logic [3:0] sel;
    logic       stall;
    logic       done;
    logic       err;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // reference model state
  int run_left = 0;    // busy cycles still owed by the unit (non-frozen ones)
  bit done_q   = 0;
  bit err_q    = 0;
  bit first    = 1;    // first cycle after reset: busy not checked
  bit seen_rst = 0;

  // pipeline stimulus state
  logic [31:0] d_nx = '0;
  logic [31:0] e_nx = '0;
  logic [31:0] pend[$];
  bit          auto_rand = 0;

  function automatic int code_of(input logic [31:0] ir);
    if (ir[31:26] != 6'd0) return 15;
    case (ir[5:0])
      6'h18: return 0;
      6'h19: return 1;
      6'h1A: return 2;
      6'h1B: return 3;
      6'h10: return 4;
      6'h12: return 5;
      6'h11: return 6;
      6'h13: return 7;
      default: return 15;
    endcase
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    logic [14:0] regs;
    regs = 15'($urandom);
    return {6'd0, regs, 5'd0, fn};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [25:0] low;
    low = 26'($urandom);
    case ($urandom_range(0, 15))
      0:  return rtype(6'h18);
      1:  return rtype(6'h19);
      2:  return rtype(6'h1A);
      3:  return rtype(6'h1B);
      4:  return rtype(6'h10);
      5:  return rtype(6'h12);
      6:  return rtype(6'h11);
      7:  return rtype(6'h13);
      8, 9: return rtype(6'h21);
      10: return {6'h23, low};
      11: return {6'h02, low[25:6], 6'h18};  // non-R op with a mult-like low field
      default: return rtype(6'h25);
    endcase
  endfunction

  function automatic logic [31:0] next_instr();
    if (pend.size() != 0) return pend.pop_front();
    if (auto_rand) return rand_instr();
    return 32'd0;
  endfunction

  task automatic chk(input string nm, input int c, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, c, act, req);
    end
  endtask

  // one clock cycle: drive inputs, predict outputs, advance the model
  task automatic cycle(input bit rn, input bit irq, input bit er,
                       input bit bflip, input bit bad_e);
    exp_t e;
    bit   running;
    int   ce, cd;
    @(posedge clk);
    #1;
    cyc++;
    IR_D = d_nx;
    IR_E = e_nx;
    if (bad_e) IR_E = rtype(6'h18 + 6'($urandom_range(0, 3)));
    running = (run_left > 0);
    clr_n   = rn;
    IntReq  = irq;
    eret    = er;
    busy    = running ^ bflip;

    ce = code_of(IR_E);
    cd = code_of(IR_D);
    e.cyc   = cyc;
    e.sel   = 4'(ce);
    e.start = rn && !running && ce <= 3 && !irq && !er;
    e.stall = rn && cd <= 7 && (e.start || running);
    e.done  = done_q;
    e.err   = err_q;
    if (seen_rst) q.push_back(e);

    if (!rn) begin
      run_left = 0;
      done_q   = 0;
      err_q    = 0;
      first    = 1;
      seen_rst = 1;
    end else begin
      if (!first && (busy != running)) err_q = 1;
      if (running && ce <= 3) err_q = 1;
      first  = 0;
      done_q = 0;
      if (running) begin
        if (!(irq || er)) begin
          run_left--;
          if (run_left == 0) done_q = 1;
        end
      end else if (e.start) begin
        run_left = (ce <= 1) ? LM : LD;
      end
    end

    // stalled: D holds, E receives a bubble
    if (e.stall) begin
      e_nx = 32'd0;
    end else begin
      e_nx = IR_D;
      d_nx = next_instr();
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("start",    e.cyc, {3'd0, start},    {3'd0, e.start});
        chk("MULTsle",  e.cyc, MULTsle,          e.sel);
        chk("stall_md", e.cyc, {3'd0, stall_md}, {3'd0, e.stall});
        chk("md_done",  e.cyc, {3'd0, md_done},  {3'd0, e.done});
        chk("err",      e.cyc, {3'd0, err},      {3'd0, e.err});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    clr_n = 1'b0; IR_D = '0; IR_E = '0; busy = 1'b0; IntReq = 1'b0; eret = 1'b0;
    repeat (3) cycle(0, 0, 0, 0, 0);

    // plain mult
    pend.push_back(rtype(6'h18));
    repeat (10) cycle(1, 0, 0, 0, 0);

    // divu followed by mflo waiting in D
    pend.push_back(rtype(6'h1B));
    pend.push_back(rtype(6'h12));
    repeat (17) cycle(1, 0, 0, 0, 0);

    // div frozen for two cycles in mid-run
    pend.push_back(rtype(6'h1A));
    for (int i = 0; i < 20; i++) cycle(1, (i == 5 || i == 6), 0, 0, 0);

    // counter at zero together with eret
    pend.push_back(rtype(6'h19));
    for (int i = 0; i < 12; i++) cycle(1, 0, (i == 7), 0, 0);

    // busy held low during a mult run, err sticky until reset
    pend.push_back(rtype(6'h18));
    for (int i = 0; i < 12; i++) cycle(1, 0, 0, (i >= 3 && i <= 6), 0);
    repeat (2) cycle(0, 0, 0, 0, 0);

    // reset on the third RUN cycle of a mult
    pend.push_back(rtype(6'h18));
    for (int i = 0; i < 10; i++) cycle((i != 5), 0, 0, 0, 0);

    // addu in D during RUN, then mthi in E while idle
    pend.push_back(rtype(6'h18));
    pend.push_back(32'd0);
    pend.push_back(rtype(6'h21));
    repeat (10) cycle(1, 0, 0, 0, 0);
    pend.push_back(rtype(6'h11));
    repeat (5) cycle(1, 0, 0, 0, 0);

    // interrupt coinciding with a start-class instruction in E
    pend.push_back(rtype(6'h1A));
    for (int i = 0; i < 4; i++) cycle(1, (i == 2), 0, 0, 0);

    // randomized traffic with rare resets and injected faults
    auto_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      cycle(!($urandom_range(0, 149) == 0),
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 24) == 0,
            $urandom_range(0, 299) == 0,
            $urandom_range(0, 399) == 0);
    end
    auto_rand = 0;
    repeat (20) cycle(1, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    chk("drain", cyc, 4'(q.size()), 4'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
